// File: rtl/soc_l2_xbar_pkg.sv
// soc_l2_xbar shared types and constants.
// Width helpers, default geometry and the response record.
package soc_l2_xbar_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    function automatic longint unsigned win_bytes(
        input int n_banks,
        input int aw
    );
        return longint'(n_banks) << (aw + 2);
    endfunction

    localparam int DEF_N_MASTERS = 4;
    localparam int DEF_N_BANKS = 4;
    localparam int DEF_ADDR_MEM_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 32;
    localparam logic [31:0] DEF_L2_BASE = 32'h1C00_0000;

    localparam int BANK_SEL_W = clog2(DEF_N_BANKS);
    localparam int MST_IDX_W = idx_w(DEF_N_MASTERS);
    localparam longint unsigned L2_WINDOW_BYTES =
        win_bytes(DEF_N_BANKS, DEF_ADDR_MEM_WIDTH);

    // Bank index storage wide enough for any legal bank count.
    localparam int RSP_IDX_W = 8;

    typedef struct packed {
        logic                 valid;
        logic                 err;
        logic                 rd;
        logic [RSP_IDX_W-1:0] bank_idx;
    } rsp_rec_t;

endpackage

// File: rtl/soc_l2_rr_arb.sv
// Round-robin arbiter, one per L2 bank.
// Pointer marks the highest-priority requester.
module soc_l2_rr_arb
    import soc_l2_xbar_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] ptr_q;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!valid_o && req_i[(int'(ptr_q) + i) % N_REQ]) begin
                valid_o = 1'b1;
                idx_o = IDX_W'((int'(ptr_q) + i) % N_REQ);
                gnt_o[(int'(ptr_q) + i) % N_REQ] = 1'b1;
            end
        end
    end

    // Pointer moves past the winner; holds when idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (valid_o) begin
            if (idx_o == IDX_W'(N_REQ - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= idx_o + 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_l2_xbar.sv
// LINT to word-interleaved L2 bank crossbar.
// Per-bank RR arbitration, 1-cycle response pipe.
module soc_l2_xbar
    import soc_l2_xbar_pkg::*;
#(
    parameter int          N_MASTERS      = DEF_N_MASTERS,
    parameter int          N_BANKS        = DEF_N_BANKS,
    parameter int          ADDR_MEM_WIDTH = DEF_ADDR_MEM_WIDTH,
    parameter int          DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter logic [31:0] L2_BASE        = DEF_L2_BASE,
    parameter int          BE_WIDTH       = DATA_WIDTH / 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_MASTERS-1:0]           req_i,
    input  logic [N_MASTERS*32-1:0]        add_i,
    input  logic [N_MASTERS-1:0]           wen_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0] wdata_i,
    input  logic [N_MASTERS*BE_WIDTH-1:0]  be_i,
    output logic [N_MASTERS-1:0]           gnt_o,
    output logic [N_MASTERS-1:0]           r_valid_o,
    output logic [N_MASTERS*DATA_WIDTH-1:0] r_rdata_o,
    output logic [N_MASTERS-1:0]           r_opc_o,
    output logic [N_BANKS-1:0]             mem_csn_o,
    output logic [N_BANKS-1:0]             mem_wen_o,
    output logic [N_BANKS*ADDR_MEM_WIDTH-1:0] mem_add_o,
    output logic [N_BANKS*DATA_WIDTH-1:0]  mem_wdata_o,
    output logic [N_BANKS*BE_WIDTH-1:0]    mem_be_o,
    input  logic [N_BANKS*DATA_WIDTH-1:0]  mem_rdata_i
);

    localparam int BANK_W = clog2(N_BANKS);
    localparam int MST_W = idx_w(N_MASTERS);
    localparam longint unsigned WIN_BYTES =
        win_bytes(N_BANKS, ADDR_MEM_WIDTH);

    logic [N_MASTERS-1:0][31:0]             off;
    logic [N_MASTERS-1:0]                   in_win;
    logic [N_MASTERS-1:0][BANK_W-1:0]       bank_sel;
    logic [N_MASTERS-1:0][ADDR_MEM_WIDTH-1:0] row;

    logic [N_BANKS-1:0][N_MASTERS-1:0]      bank_req;
    logic [N_BANKS-1:0][N_MASTERS-1:0]      bank_gnt;
    logic [N_BANKS-1:0][MST_W-1:0]          arb_idx;
    logic [N_BANKS-1:0]                     arb_valid;

    rsp_rec_t [N_MASTERS-1:0]               rsp_q;

    // Window check and bank/row split of each address.
    always_comb begin
        for (int m = 0; m < N_MASTERS; m++) begin
            off[m] = add_i[m*32 +: 32] - L2_BASE;
            in_win[m] = 64'(off[m]) < WIN_BYTES;
            bank_sel[m] = off[m][2 +: BANK_W];
            row[m] = off[m][2+BANK_W +: ADDR_MEM_WIDTH];
        end
    end

    // In-window requests steered to their bank; none in reset.
    always_comb begin
        for (int b = 0; b < N_BANKS; b++) begin
            for (int m = 0; m < N_MASTERS; m++) begin
                bank_req[b][m] = ~rst_i & req_i[m] & in_win[m]
                               & (bank_sel[m] == BANK_W'(b));
            end
        end
    end

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        soc_l2_rr_arb #(
            .N_REQ (N_MASTERS),
            .IDX_W (MST_W)
        ) u_arb (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .req_i   (bank_req[b]),
            .gnt_o   (bank_gnt[b]),
            .idx_o   (arb_idx[b]),
            .valid_o (arb_valid[b])
        );
    end

    // Out-of-window requests never wait for a bank.
    always_comb begin
        for (int m = 0; m < N_MASTERS; m++) begin
            gnt_o[m] = ~rst_i & req_i[m]
                     & (~in_win[m] | bank_gnt[bank_sel[m]][m]);
        end
    end

    // Winner drives its bank; idle banks are deselected and zero.
    always_comb begin
        mem_csn_o = '1;
        mem_wen_o = '0;
        mem_add_o = '0;
        mem_wdata_o = '0;
        mem_be_o = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            if (arb_valid[b]) begin
                mem_csn_o[b] = 1'b0;
                mem_wen_o[b] = wen_i[arb_idx[b]];
                mem_add_o[b*ADDR_MEM_WIDTH +: ADDR_MEM_WIDTH] =
                    row[arb_idx[b]];
                mem_wdata_o[b*DATA_WIDTH +: DATA_WIDTH] =
                    wdata_i[int'(arb_idx[b])*DATA_WIDTH +: DATA_WIDTH];
                mem_be_o[b*BE_WIDTH +: BE_WIDTH] =
                    be_i[int'(arb_idx[b])*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    // Record each grant so its response fires next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_q <= '0;
        end else begin
            for (int m = 0; m < N_MASTERS; m++) begin
                rsp_q[m].valid <= gnt_o[m];
                rsp_q[m].err <= ~in_win[m];
                rsp_q[m].rd <= wen_i[m];
                rsp_q[m].bank_idx <= RSP_IDX_W'(bank_sel[m]);
            end
        end
    end

    // Only successful reads carry bank data back.
    always_comb begin
        r_valid_o = '0;
        r_opc_o = '0;
        r_rdata_o = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            r_valid_o[m] = rsp_q[m].valid;
            r_opc_o[m] = rsp_q[m].valid & rsp_q[m].err;
            if (rsp_q[m].valid && !rsp_q[m].err && rsp_q[m].rd) begin
                r_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] =
                    mem_rdata_i[int'(rsp_q[m].bank_idx)*DATA_WIDTH
                                +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_soc_l2_xbar.sv
// Bench for soc_l2_xbar: directed table, corner
// sequences and random traffic vs a flat-memory model.
module tb_soc_l2_xbar;
    import soc_l2_xbar_pkg::*;

    localparam int NM = DEF_N_MASTERS;
    localparam int NB = DEF_N_BANKS;
    localparam int AW = DEF_ADDR_MEM_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;
    localparam int BW = DW / 8;
    localparam logic [31:0] BASE = DEF_L2_BASE;
    localparam int WORDS = NB << AW;
    localparam logic [31:0] WIN = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst;
    logic [NM-1:0] req, wen, gnt, rv, opc;
    logic [NM*32-1:0] add;
    logic [NM*DW-1:0] wdata, rdata;
    logic [NM*BW-1:0] be;
    logic [NB-1:0] csn, mwen;
    logic [NB*AW-1:0] madd;
    logic [NB*DW-1:0] mwdata, mrdata;
    logic [NB*BW-1:0] mbe;

    soc_l2_xbar #(
        .N_MASTERS(NM), .N_BANKS(NB), .ADDR_MEM_WIDTH(AW),
        .DATA_WIDTH(DW), .L2_BASE(BASE)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add),
        .wen_i(wen), .wdata_i(wdata), .be_i(be), .gnt_o(gnt),
        .r_valid_o(rv), .r_rdata_o(rdata), .r_opc_o(opc),
        .mem_csn_o(csn), .mem_wen_o(mwen), .mem_add_o(madd),
        .mem_wdata_o(mwdata), .mem_be_o(mbe), .mem_rdata_i(mrdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int w);
        if (w == 4) return 32'hDEAD_BEEF;
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Bank SRAM macros: 1-cycle read latency.
    logic [DW-1:0] sram [NB][1<<AW];
    logic [DW-1:0] sram_q [NB];

    always @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                sram_q[b] <= '0;
                for (int r = 0; r < (1 << AW); r++)
                    sram[b][r] <= init_word(r * NB + b);
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (!csn[b]) begin
                    if (mwen[b])
                        sram_q[b] <= sram[b][madd[b*AW +: AW]];
                    else
                        for (int k = 0; k < BW; k++)
                            if (mbe[b*BW+k])
                                sram[b][madd[b*AW +: AW]][k*8 +: 8]
                                    <= mwdata[b*DW + k*8 +: 8];
                end
            end
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_rd
        assign mrdata[b*DW +: DW] = sram_q[b];
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Stimulus and reference model state.
    logic [NM-1:0] s_req, s_wen;
    logic [31:0] s_add [NM];
    logic [DW-1:0] s_wd [NM];
    logic [BW-1:0] s_be [NM];
    int ptr [NB];
    logic [DW-1:0] flat [WORDS];
    logic [NM-1:0] e_gnt, e_rv, e_opc, c_gnt;
    logic [NB-1:0] e_csn, c_csn;
    logic [AW-1:0] e_row [NB];
    logic [DW-1:0] e_rd [NM];

    task automatic model_reset();
        for (int b = 0; b < NB; b++) ptr[b] = 0;
        for (int w = 0; w < WORDS; w++) flat[w] = init_word(w);
    endtask

    task automatic predict();
        logic [31:0] off;
        bit inw [NM];
        int wrd [NM];
        int bk [NM];
        bit found;
        int m;
        e_gnt = '0;
        e_csn = '1;
        for (int i = 0; i < NM; i++) begin
            off = s_add[i] - BASE;
            inw[i] = off < WIN;
            wrd[i] = int'(off >> 2);
            bk[i] = wrd[i] % NB;
            if (s_req[i] && !inw[i]) e_gnt[i] = 1'b1;
        end
        for (int b = 0; b < NB; b++) begin
            found = 0;
            e_row[b] = '0;
            for (int k = 0; k < NM; k++) begin
                m = (ptr[b] + k) % NM;
                if (!found && s_req[m] && inw[m] && bk[m] == b) begin
                    found = 1;
                    e_gnt[m] = 1'b1;
                    e_csn[b] = 1'b0;
                    e_row[b] = AW'(wrd[m] / NB);
                    ptr[b] = (m + 1) % NM;
                end
            end
        end
        for (int i = 0; i < NM; i++) begin
            e_rv[i] = e_gnt[i];
            e_opc[i] = e_gnt[i] && !inw[i];
            e_rd[i] = (e_gnt[i] && inw[i] && s_wen[i])
                    ? flat[wrd[i]] : '0;
        end
        for (int i = 0; i < NM; i++)
            if (e_gnt[i] && inw[i] && !s_wen[i])
                for (int k = 0; k < BW; k++)
                    if (s_be[i][k])
                        flat[wrd[i]][k*8 +: 8] = s_wd[i][k*8 +: 8];
    endtask

    task automatic drive();
        for (int i = 0; i < NM; i++) begin
            req[i] = s_req[i];
            wen[i] = s_wen[i];
            add[i*32 +: 32] = s_add[i];
            wdata[i*DW +: DW] = s_wd[i];
            be[i*BW +: BW] = s_be[i];
        end
    endtask

    // One clock: grant/bank checks mid-cycle, responses after edge.
    task automatic step();
        drive();
        #1;
        predict();
        @(negedge clk);
        c_gnt = gnt;
        c_csn = csn;
        chk("gnt", gnt, e_gnt);
        chk("csn", csn, e_csn);
        for (int b = 0; b < NB; b++)
            chk("mem_add", madd[b*AW +: AW], e_row[b]);
        @(posedge clk);
        #1;
        chk("r_valid", rv, e_rv);
        chk("r_opc", opc, e_opc);
        for (int i = 0; i < NM; i++)
            chk("r_rdata", rdata[i*DW +: DW], e_rd[i]);
    endtask

    typedef struct packed {
        logic [NM-1:0]       req;
        logic [NM-1:0]       wen;
        logic [NM-1:0][31:0] add;
        logic [DW-1:0]       wd;
        logic [BW-1:0]       be;
        logic [NM-1:0]       x_gnt;
        logic [NB-1:0]       x_csn;
        logic [NM-1:0]       x_opc;
    } vec_t;

    function automatic vec_t mkv(
        input logic [NM-1:0] rq, input logic [NM-1:0] we,
        input logic [31:0] a0, input logic [31:0] a1,
        input logic [31:0] a2, input logic [31:0] a3,
        input logic [DW-1:0] wd, input logic [BW-1:0] b,
        input logic [NM-1:0] xg, input logic [NB-1:0] xc,
        input logic [NM-1:0] xo);
        vec_t v;
        v.req = rq; v.wen = we;
        v.add[0] = a0; v.add[1] = a1;
        v.add[2] = a2; v.add[3] = a3;
        v.wd = wd; v.be = b;
        v.x_gnt = xg; v.x_csn = xc; v.x_opc = xo;
        return v;
    endfunction

    vec_t tab [14];

    task automatic set_all_bank2();
        s_req = '1;
        s_wen = '1;
        s_add[0] = BASE + 32'h08;
        s_add[1] = BASE + 32'h18;
        s_add[2] = BASE + 32'h28;
        s_add[3] = BASE + 32'h38;
    endtask

    initial begin
        logic [31:0] b2, b18, b28, b38;
        b2 = BASE + 32'h08; b18 = BASE + 32'h18;
        b28 = BASE + 32'h28; b38 = BASE + 32'h38;
        tab[0]  = mkv(4'b0001, 4'hF, BASE+32'h10, 0, 0, 0,
                      0, 0, 4'b0001, 4'b1110, 4'b0000);
        tab[1]  = mkv(4'b1111, 4'hF, b2, b18, b28, b38,
                      0, 0, 4'b0001, 4'b1011, 4'b0000);
        tab[2]  = mkv(4'b1110, 4'hF, b2, b18, b28, b38,
                      0, 0, 4'b0010, 4'b1011, 4'b0000);
        tab[3]  = mkv(4'b1100, 4'hF, b2, b18, b28, b38,
                      0, 0, 4'b0100, 4'b1011, 4'b0000);
        tab[4]  = mkv(4'b1000, 4'hF, b2, b18, b28, b38,
                      0, 0, 4'b1000, 4'b1011, 4'b0000);
        tab[5]  = mkv(4'b0100, 4'hF, b2, b18, b28, b38,
                      0, 0, 4'b0100, 4'b1011, 4'b0000);
        tab[6]  = mkv(4'b1111, 4'hF, BASE, BASE+32'h4,
                      BASE+32'h8, BASE+32'hC,
                      0, 0, 4'b1111, 4'b0000, 4'b0000);
        tab[7]  = mkv(4'b0010, 4'hF, 0, 32'h1A00_0000, 0, 0,
                      0, 0, 4'b0010, 4'b1111, 4'b0010);
        tab[8]  = mkv(4'b0111, 4'hF, BASE+32'hFFFC, BASE+WIN,
                      BASE-32'h4, 0,
                      0, 0, 4'b0111, 4'b0111, 4'b0110);
        tab[9]  = mkv(4'b1000, 4'b0111, 0, 0, 0, BASE+32'h20,
                      32'h1234_5678, 4'b0011,
                      4'b1000, 4'b1110, 4'b0000);
        tab[10] = mkv(4'b1000, 4'hF, 0, 0, 0, BASE+32'h20,
                      0, 0, 4'b1000, 4'b1110, 4'b0000);
        tab[11] = mkv(4'b0100, 4'hF, 0, 0, BASE+32'h13, 0,
                      0, 0, 4'b0100, 4'b1110, 4'b0000);
        tab[12] = mkv(4'b0111, 4'hF, 32'h0, BASE+32'h4,
                      BASE+32'h14, 0,
                      0, 0, 4'b0101, 4'b1101, 4'b0001);
        tab[13] = mkv(4'b0010, 4'hF, 0, BASE+32'h4, 0, 0,
                      0, 0, 4'b0010, 4'b1101, 4'b0000);

        // Reset with requests pending.
        rst = 1'b1;
        model_reset();
        set_all_bank2();
        for (int i = 0; i < NM; i++) begin
            s_wd[i] = '0;
            s_be[i] = '0;
        end
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_csn", csn, 4'hF);
        chk("rst_rv", rv, 0);
        chk("rst_opc", opc, 0);
        chk("rst_rdata", rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        s_req = '0;
        drive();
        @(posedge clk);
        #1;

        // Directed table.
        for (int t = 0; t < 14; t++) begin
            s_req = tab[t].req;
            s_wen = tab[t].wen;
            for (int i = 0; i < NM; i++) begin
                s_add[i] = tab[t].add[i];
                s_wd[i] = tab[t].wd;
                s_be[i] = tab[t].be;
            end
            step();
            chk($sformatf("tab%0d_gnt", t), c_gnt, tab[t].x_gnt);
            chk($sformatf("tab%0d_csn", t), c_csn, tab[t].x_csn);
            chk($sformatf("tab%0d_rv", t), rv, tab[t].x_gnt);
            chk($sformatf("tab%0d_opc", t), opc, tab[t].x_opc);
            if (t == 0)
                chk("single_rd", rdata[0 +: DW], 32'hDEAD_BEEF);
            if (t == 10)
                chk("wr_rd", rdata[3*DW +: DW],
                    (init_word(8) & 32'hFFFF_0000) | 32'h5678);
            if (t == 11)
                chk("unaligned_rd", rdata[2*DW +: DW], 32'hDEAD_BEEF);
        end

        // Reset one cycle after a grant drops the response.
        s_req = 4'b0011;
        s_wen = '1;
        s_add[0] = BASE;
        s_add[1] = BASE + 32'h08;
        step();
        s_req = '0;
        drive();
        rst = 1'b1;
        #1;
        chk("async_rst_rv", rv, 0);
        set_all_bank2();
        drive();
        #1;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_csn", csn, 4'hF);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        s_req = '0;
        drive();
        @(posedge clk);
        #1;
        chk("no_stale_rv", rv, 0);
        set_all_bank2();
        step();
        chk("ptr_after_rst", c_gnt, 4'b0001);

        // Random traffic; ungranted requests are held.
        e_gnt = '1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NM; i++) begin
                if (!s_req[i] || e_gnt[i]) begin
                    s_req[i] = ($urandom % 3) != 0;
                    s_wen[i] = $urandom % 2;
                    s_wd[i] = $urandom;
                    s_be[i] = BW'($urandom);
                    case ($urandom % 8)
                        0: s_add[i] = 32'h2000_0000 | ($urandom % 4096);
                        1: s_add[i] = BASE - 32'(4 * ($urandom_range(1, 8)));
                        2: s_add[i] = BASE + ($urandom % (WIN + 64));
                        default:
                            s_add[i] = BASE + 32'($urandom_range(0, 15) * 4)
                                     + 32'($urandom % 4);
                    endcase
                end
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
